tod_counter_12_24: RTL

Parametrised time-of-day counter with selectable 12/24-hour display formatting. Divides the system clock into a one-second tick, keeps hours/minutes/seconds in 24-hour form, and accepts a time-set via a valid/ready handshake. The block feeds the display path directly with hour_disp/is_pm and sits between the board clock and the seven-segment driver.

---
 rtl/tod_pkg.sv | 29 ++
 rtl/tod_hour_fmt.sv | 27 ++
 rtl/tod_counter_12_24.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/tod_pkg.sv
// Shared constants, FSM state type and time payload for the time-of-day counter.
package tod_pkg;

    localparam int unsigned HOUR_W   = 5;
    localparam int unsigned MS_W     = 6;
    localparam int unsigned HOUR_MAX = 23;
    localparam int unsigned MIN_MAX  = 59;
    localparam int unsigned SEC_MAX  = 59;

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_LOAD = 2'd2
    } tod_state_e;

    typedef struct packed {
        logic [HOUR_W-1:0] hour;
        logic [MS_W-1:0]   min;
        logic [MS_W-1:0]   sec;
    } tod_time_t;

    // True when every field of a requested time is in range
    function automatic logic time_ok(tod_time_t t);
        return (t.hour <= HOUR_W'(HOUR_MAX)) &&
               (t.min  <= MS_W'(MIN_MAX))    &&
               (t.sec  <= MS_W'(SEC_MAX));
    endfunction

endpackage

// File: rtl/tod_hour_fmt.sv
// Combinational hour formatter: 24 h passthrough or 12 h with PM flag.
module tod_hour_fmt
    import tod_pkg::*;
(
    input  logic [HOUR_W-1:0] hour24,
    input  logic              mode_12h,
    output logic [HOUR_W-1:0] hour_disp_c,
    output logic              is_pm_c
);

    always_comb begin
        hour_disp_c = hour24;
        is_pm_c     = 1'b0;
        if (mode_12h) begin
            if (hour24 == HOUR_W'(0)) begin
                hour_disp_c = HOUR_W'(12);
            end else if (hour24 == HOUR_W'(12)) begin
                hour_disp_c = HOUR_W'(12);
                is_pm_c     = 1'b1;
            end else if (hour24 > HOUR_W'(12)) begin
                hour_disp_c = hour24 - HOUR_W'(12);
                is_pm_c     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tod_counter_12_24.sv
// Time-of-day counter with one-second prescaler, set handshake and 12/24 h display.
// Optional alarm comparator enabled by defining TOD_ALARM_EN.
module tod_counter_12_24
    import tod_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              mode_12h,
    input  logic              set_valid,
    output logic              set_ready,
    input  logic [HOUR_W-1:0] set_hour,
    input  logic [MS_W-1:0]   set_min,
    input  logic [MS_W-1:0]   set_sec,
    output logic              set_err,
    output logic [HOUR_W-1:0] hour24,
    output logic [MS_W-1:0]   min,
    output logic [MS_W-1:0]   sec,
    output logic [HOUR_W-1:0] hour_disp,
    output logic              is_pm,
    output logic              sec_pulse,
    output logic              day_wrap
`ifdef TOD_ALARM_EN
    ,
    input  logic [HOUR_W-1:0] alarm_hour,
    input  logic [MS_W-1:0]   alarm_min,
    input  logic              alarm_arm,
    output logic              alarm_hit
`endif
);

    localparam int unsigned PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_HZ - 1);

    tod_state_e        state;
    tod_state_e        state_next;
    logic [PRE_W-1:0]  pre;
    tod_time_t         cur;
    tod_time_t         nxt;
    tod_time_t         set_val;
    logic              ready_q;
    logic              hs_c;
    logic              set_ok_c;
    logic              count_en_c;
    logic              tick_c;
    logic              load_c;
    logic              adv_c;
    logic              last_sec_c;

    assign set_val  = {set_hour, set_min, set_sec};
    assign set_ok_c = time_ok(set_val);
    assign hs_c     = set_valid & ready_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_STOP;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_STOP, ST_RUN: begin
                if (hs_c)     state_next = ST_LOAD;
                else if (run) state_next = ST_RUN;
                else          state_next = ST_STOP;
            end
            ST_LOAD: state_next = run ? ST_RUN : ST_STOP;
            default: state_next = ST_STOP;
        endcase
    end

    // Per-state control decode; a committed set pre-empts a same-cycle tick
    always_comb begin
        count_en_c = 1'b0;
        tick_c     = 1'b0;
        load_c     = 1'b0;
        adv_c      = 1'b0;
        if (state == ST_RUN) begin
            count_en_c = 1'b1;
            tick_c     = (pre == PRE_LAST);
        end
        load_c = hs_c & set_ok_c;
        adv_c  = tick_c & ~load_c;
    end

    // Next time on a tick, with cascaded carries
    always_comb begin
        nxt = cur;
        if (cur.sec == MS_W'(SEC_MAX)) begin
            nxt.sec = '0;
            if (cur.min == MS_W'(MIN_MAX)) begin
                nxt.min  = '0;
                nxt.hour = (cur.hour == HOUR_W'(HOUR_MAX)) ? '0 : cur.hour + HOUR_W'(1);
            end else begin
                nxt.min = cur.min + MS_W'(1);
            end
        end else begin
            nxt.sec = cur.sec + MS_W'(1);
        end
    end

    assign last_sec_c = (cur.hour == HOUR_W'(HOUR_MAX)) &&
                        (cur.min  == MS_W'(MIN_MAX))    &&
                        (cur.sec  == MS_W'(SEC_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur       <= '0;
            pre       <= '0;
            ready_q   <= 1'b1;
            sec_pulse <= 1'b0;
            day_wrap  <= 1'b0;
            set_err   <= 1'b0;
        end else begin
            ready_q   <= (state_next != ST_LOAD);
            sec_pulse <= adv_c;
            day_wrap  <= adv_c & last_sec_c;
            set_err   <= hs_c & ~set_ok_c;
            if (load_c) begin
                cur <= set_val;
                pre <= '0;
            end else begin
                if (count_en_c) pre <= tick_c ? '0 : pre + PRE_W'(1);
                if (adv_c)      cur <= nxt;
            end
        end
    end

`ifdef TOD_ALARM_EN
    // Fires only when a tick lands on the alarm minute, never on a load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_hit <= 1'b0;
        end else begin
            alarm_hit <= adv_c & alarm_arm &
                         (nxt.hour == alarm_hour) &&
                         (nxt.min == alarm_min) &&
                         (nxt.sec == '0);
        end
    end
`endif

    assign set_ready = ready_q;
    assign hour24    = cur.hour;
    assign min       = cur.min;
    assign sec       = cur.sec;

    tod_hour_fmt u_fmt (
        .hour24      (cur.hour),
        .mode_12h    (mode_12h),
        .hour_disp_c (hour_disp),
        .is_pm_c     (is_pm)
    );

endmodule
